layer_mac_scheduler: RTL and testbench
======================================

// Module: layer_mac_scheduler
// PURPOSE
//  Time-multiplexed sequencer for one fully-connected ReLU layer. It shares a single 16-bit MAC across N_OUT neurons.
//  Latches an N_IN-wide activation vector on start, then fetches weights and bias from an external synchronous ROM.
//  Emits one ReLU-clamped neuron result per neuron over a valid/ready stream.
//  Sits between the previous layer's output register bank and the next layer's input buffer.
//  Replaces N_OUT parallel per-neuron node instances.
// PARAMETERS
//  N_IN   15  activations per neuron (>=1)
//  N_OUT  16  neurons in the layer (>=1)
//  DW     16  datapath width; two's complement; products and sums truncated to DW
//  AW     $clog2(N_OUT*(N_IN+1))  ROM address width
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  start      in   1        pulse: latch a_vec and begin a layer pass (accepted only in IDLE)
//  a_vec      in   N_IN*DW  activations; element i at [i*DW +: DW]
//  busy       out  1        high from the cycle after start is accepted until done
//  done       out  1        one-cycle pulse after the last result handshake
//  rom_addr   out  AW       weight/bias address; neuron n, slot j -> n*(N_IN+1)+j; slot N_IN = bias
//  rom_en     out  1        read strobe; data returns on rom_data exactly 1 cycle later
//  rom_data   in   DW       weight/bias data
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accept
//  out_idx    out  $clog2(N_OUT)  neuron index of out_data
//  out_data   out  DW       ReLU(sum): 0 if sum[DW-1]==1, else sum
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; accumulator, counters and a_vec latch all 0.
//  FSM states and transitions:
//   IDLE  -> FETCH on start. a_vec is latched. n=0, j=0.
//   FETCH: rom_en=1 and rom_addr=n*(N_IN+1)+j, one address per cycle, j=0..N_IN (N_IN+1 cycles).
//    The rom_data returned for the previous address is accumulated.
//    Accumulator is cleared to 0 on the first FETCH cycle of each neuron.
//    After j=N_IN -> DRAIN.
//   DRAIN: rom_en=0. Adds the bias (last returned word) to acc -> EMIT.
//   EMIT: out_valid=1; out_idx=n; out_data=ReLU(acc).
//    out_data and out_idx are held stable while out_valid && !out_ready.
//    On out_valid && out_ready: if n==N_OUT-1 -> DONE, else n++, j=0 -> FETCH.
//   DONE: done=1 for one cycle; busy drops in the same cycle -> IDLE.
//  MAC arithmetic: acc <= acc + trunc_DW(a[j] * w). The product is taken as DW x DW and truncated to low DW bits.
//   Accumulation wraps modulo 2^DW; no saturation. Bit-exact with per-neuron node output.
//  Latency with out_ready tied high: N_IN+3 cycles per neuron.
//   Total start->done = N_OUT*(N_IN+3)+1 cycles; 289 for the defaults.
//  start while not IDLE: ignored; the latched a_vec is unchanged.
//  a_vec changing during a pass: no effect; only the value latched at start is used.
//  out_ready high while out_valid is low: no effect.
//  Simultaneous done and start in the same cycle: start is ignored. A new start is accepted from IDLE on the next cycle.
//  Reset asserted mid-pass: immediate return to IDLE. All outputs go to 0. No done pulse. The partial result is discarded.
//  rom_en is never high outside FETCH. rom_addr holds its last value when rom_en=0.
// STRUCTURE
//  Shared package layer_pkg holds:
//   the DW constant;
//   the FSM enum {IDLE,FETCH,DRAIN,EMIT,DONE};
//   function relu(DW) -> DW;
//   function rom_base(n) = n*(N_IN+1).
//  One sub-module, mac_unit: operands a, w and the acc register.
//   Controls: clr (clear) and en (accumulate). Arithmetic is truncating and wrapping.
//  The scheduler holds the FSM, the j/n counters, the a_vec latch, the delayed-slot mux and the output register.
// TESTING
//  1. All w=1, bias=1, a=2, out_ready=1 -> 16 results of 31, idx 0..15 in order; done at cycle 289 after start.
//  2. All w=-1 (16'hFFFF), bias=0, a=3 -> every out_data=0 (ReLU clamp); done still pulses once.
//  3. a0=16'h4000, w0=2, other w=0, bias=0 -> sum=16'h8000 after wrap, so out_data=0.
//     Same case with w0=1 -> out_data=16'h4000.
//  4. out_ready low for 5 cycles at neuron 3 -> out_valid stays high and out_data/out_idx stay stable; no ROM reads.
//     Release -> neuron 4 starts the next cycle.
//  5. start re-pulsed at cycle 50 with a different a_vec -> ignored; results match the first vector.
//  6. reset low at cycle 100 mid-FETCH -> all outputs 0 and no done.
//     A new start afterwards -> correct full pass (scenario 1 values).

Source files
------------

// File: rtl/layer_mac_scheduler_pkg.sv
// Shared definitions for the layer MAC scheduler.
//   DW        : datapath width (two's complement, truncating/wrapping arithmetic)
//   state_e   : scheduler FSM states
//   relu()    : clamp negative values to zero
//   rom_base(): first ROM address of a neuron's weight/bias block
package layer_mac_scheduler_pkg;

    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StEmit,
        StDone
    } state_e;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    // Each neuron owns N_IN weights followed by one bias word.
    function automatic int unsigned rom_base(input int unsigned n, input int unsigned n_in);
        return n * (n_in + 1);
    endfunction

endpackage

// File: rtl/layer_mac_scheduler_if.sv
// Bundle of the scheduler's control, ROM and result-stream signals.
//   start/a_vec        : layer pass request and activation vector
//   busy/done          : pass status
//   rom_addr/rom_en    : weight/bias read request, rom_data returns one cycle later
//   out_valid/out_ready: result stream handshake carrying out_idx/out_data
// Modport slave is the scheduler side, master is the surrounding system.
interface layer_mac_scheduler_if #(
    parameter int unsigned N_IN  = 15,
    parameter int unsigned N_OUT = 16
) ();
    import layer_mac_scheduler_pkg::*;

    localparam int unsigned AW = $clog2(N_OUT * (N_IN + 1));
    localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                 start;
    logic [N_IN*DW-1:0]   a_vec;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        rom_addr;
    logic                 rom_en;
    logic [DW-1:0]        rom_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [IW-1:0]        out_idx;
    logic [DW-1:0]        out_data;

    modport master (
        output start, a_vec, rom_data, out_ready,
        input  busy, done, rom_addr, rom_en, out_valid, out_idx, out_data
    );

    modport slave (
        input  start, a_vec, rom_data, out_ready,
        output busy, done, rom_addr, rom_en, out_valid, out_idx, out_data
    );

endinterface

// File: rtl/layer_mac_scheduler_mac_unit.sv
// Single shared multiply-accumulate unit.
//   clk, reset : clock, asynchronous active-low reset
//   i_clr      : clear accumulator (wins over i_en)
//   i_en       : accumulate i_a * i_w
//   i_a, i_w   : operands
//   o_sum      : accumulator plus current product (value loaded when i_en is high)
// Product and sum are truncated to DW bits and wrap; no saturation.
module layer_mac_scheduler_mac_unit
    import layer_mac_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_w,
    output logic [DW-1:0] o_sum
);

    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_prod;

    // Evaluated at DW bits, so only the low half of the full product is kept.
    assign w_prod = i_a * i_w;
    assign o_sum  = r_acc + w_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed sequencer for one fully-connected ReLU layer sharing one MAC.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : start/a_vec in, busy/done out, ROM read port, result stream (see interface)
// Per neuron: N_IN+1 FETCH cycles (weights then bias), one DRAIN cycle, then EMIT
// until the result is accepted.
module layer_mac_scheduler
    import layer_mac_scheduler_pkg::*;
#(
    parameter int unsigned N_IN  = 15,
    parameter int unsigned N_OUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    layer_mac_scheduler_if.slave   bus
);

    localparam int unsigned AW = $clog2(N_OUT * (N_IN + 1));
    localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned JW = $clog2(N_IN + 1);

    state_e           r_state;
    logic [JW-1:0]    r_j;
    logic [IW-1:0]    r_n;
    logic [DW-1:0]    r_a [N_IN];
    logic             r_busy;
    logic             r_done;
    logic             r_rom_en;
    logic [AW-1:0]    r_rom_addr;
    logic             r_out_valid;
    logic [IW-1:0]    r_out_idx;
    logic [DW-1:0]    r_out_data;

    logic             w_last_slot;
    logic             w_last_neuron;
    logic             w_mac_clr;
    logic             w_mac_en;
    logic [DW-1:0]    w_mac_a;
    logic [DW-1:0]    w_sum;
    logic [AW-1:0]    w_next_base;

    assign w_last_slot   = (r_j == JW'(N_IN));
    assign w_last_neuron = (r_n == IW'(N_OUT - 1));
    assign w_next_base   = AW'(rom_base(32'(r_n) + 32'd1, N_IN));

    // rom_data always belongs to the address issued one cycle earlier, so the
    // activation is picked with slot j-1; in DRAIN the bias passes through (a=1).
    assign w_mac_clr = (r_state == StFetch) && (r_j == '0);
    assign w_mac_en  = ((r_state == StFetch) && (r_j != '0)) || (r_state == StDrain);

    always_comb begin
        w_mac_a = '0;
        if (r_state == StDrain) begin
            w_mac_a = DW'(1);
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (r_j == JW'(i + 1)) begin
                    w_mac_a = r_a[i];
                end
            end
        end
    end

    layer_mac_scheduler_mac_unit u_mac (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_a   (w_mac_a),
        .i_w   (bus.rom_data),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_j         <= '0;
            r_n         <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_a[i] <= '0;
            end
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_IN; i++) begin
                            r_a[i] <= bus.a_vec[i*DW +: DW];
                        end
                        r_n        <= '0;
                        r_j        <= '0;
                        r_busy     <= 1'b1;
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= '0;
                        r_state    <= StFetch;
                    end
                end
                StFetch: begin
                    if (w_last_slot) begin
                        // rom_addr keeps the bias address while the port is idle.
                        r_rom_en <= 1'b0;
                        r_state  <= StDrain;
                    end else begin
                        r_j        <= r_j + JW'(1);
                        r_rom_addr <= r_rom_addr + AW'(1);
                    end
                end
                StDrain: begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_n;
                    r_out_data  <= relu(w_sum);
                    r_state     <= StEmit;
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_neuron) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_n        <= r_n + IW'(1);
                            r_j        <= '0;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= w_next_base;
                            r_state    <= StFetch;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rom_en    = r_rom_en;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler with the default 15x16 geometry.
// A synchronous ROM model answers reads one cycle later; a monitor logs every
// accepted result and done pulse.
module tb_layer_mac_scheduler;
    import layer_mac_scheduler_pkg::*;

    localparam int unsigned NI = 15;
    localparam int unsigned NO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    layer_mac_scheduler_if #(.N_IN(NI), .N_OUT(NO)) bus ();

    layer_mac_scheduler #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] rom [256];

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    int          cyc = 0;
    int          n_res = 0;
    int          n_done = 0;
    int          n_rom_emit = 0;
    logic [3:0]  res_idx [256];
    logic [15:0] res_data [256];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.out_valid && bus.out_ready && n_res < 256) begin
            res_idx[n_res]  = bus.out_idx;
            res_data[n_res] = bus.out_data;
            n_res = n_res + 1;
        end
        if (bus.done) n_done = n_done + 1;
        if (bus.out_valid && bus.rom_en) n_rom_emit = n_rom_emit + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NI*16-1:0] vec_all(input logic [15:0] a);
        logic [NI*16-1:0] v;
        for (int i = 0; i < NI; i++) v[i*16 +: 16] = a;
        return v;
    endfunction

    function automatic logic [NI*16-1:0] vec_inc();
        logic [NI*16-1:0] v;
        for (int i = 0; i < NI; i++) v[i*16 +: 16] = 16'(i + 1);
        return v;
    endfunction

    task automatic rom_uniform(input logic [15:0] w, input logic [15:0] b);
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < 16; j++) rom[n*16 + j] = (j == 15) ? b : w;
    endtask

    // Neuron n: weight 1 at slot n%15, bias n -> sum = (n%15 + 1) + n with vec_inc.
    task automatic rom_varied();
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < 16; j++)
                rom[n*16 + j] = (j == 15) ? 16'(n) : ((j == n % 15) ? 16'd1 : 16'd0);
    endtask

    task automatic rom_slot0(input logic [15:0] w);
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < 16; j++) rom[n*16 + j] = (j == 0) ? w : 16'd0;
    endtask

    task automatic do_start(input logic [NI*16-1:0] v, output int sc);
        bus.start = 1'b1;
        bus.a_vec = v;
        tick();
        sc = cyc;
        bus.start = 1'b0;
    endtask

    // Latency counts from the cycle start is high (0) to the cycle done is high.
    task automatic wait_done(input string tag, input int sc, input int dbase,
                             input int exp_lat, input bit collide);
        int k;
        int lat;
        k = 0;
        while (!bus.done && k < 2000) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        lat = cyc - sc + 1;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        if (collide) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_done_count"}, n_done - dbase, 32'd1);
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_results(input string tag, input int base, input bit varied,
                                 input logic [15:0] val);
        logic [15:0] exp;
        chk({tag, "_count"}, n_res - base, 32'd16);
        for (int n = 0; n < 16; n++) begin
            exp = varied ? ((n < 15) ? 16'(2 * n + 1) : 16'd16) : val;
            chk({tag, "_idx"}, 32'(res_idx[base + n]), 32'(n));
            chk({tag, "_data"}, 32'(res_data[base + n]), 32'(exp));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rom_en"}, 32'(bus.rom_en), 32'd0);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int base;
        int dbase;
        int k;

        bus.start = 1'b0;
        bus.a_vec = '0;
        bus.out_ready = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        chk("reset_release_busy", 32'(bus.busy), 32'd0);

        // 1: uniform weights, 15*2 + 1 = 31 per neuron
        rom_uniform(16'd1, 16'd1);
        base = n_res;
        dbase = n_done;
        do_start(vec_all(16'd2), sc);
        chk("s1_busy", 32'(bus.busy), 32'd1);
        chk("s1_rom_en", 32'(bus.rom_en), 32'd1);
        chk("s1_addr0", 32'(bus.rom_addr), 32'd0);
        tick();
        chk("s1_addr1", 32'(bus.rom_addr), 32'd1);
        wait_done("s1", sc, dbase, 289, 1'b0);
        check_results("s1", base, 1'b0, 16'd31);

        // Per-neuron distinct weights and biases
        rom_varied();
        base = n_res;
        dbase = n_done;
        do_start(vec_inc(), sc);
        wait_done("s1v", sc, dbase, 289, 1'b0);
        check_results("s1v", base, 1'b1, 16'd0);

        // 2: 15 * (3 * -1) = -45 clamps to 0; start during done is ignored
        rom_uniform(16'hFFFF, 16'd0);
        base = n_res;
        dbase = n_done;
        do_start(vec_all(16'd3), sc);
        wait_done("s2", sc, dbase, 289, 1'b1);
        check_results("s2", base, 1'b0, 16'd0);
        chk("s2_no_restart_rom_en", 32'(bus.rom_en), 32'd0);

        // 3: 0x4000 * 2 wraps to 0x8000 -> clamped; with w=1 -> 0x4000
        rom_slot0(16'd2);
        base = n_res;
        dbase = n_done;
        do_start({{(NI-1)*16{1'b0}}, 16'h4000}, sc);
        wait_done("s3a", sc, dbase, 289, 1'b0);
        check_results("s3a", base, 1'b0, 16'd0);
        rom_slot0(16'd1);
        base = n_res;
        dbase = n_done;
        do_start({{(NI-1)*16{1'b0}}, 16'h4000}, sc);
        wait_done("s3b", sc, dbase, 289, 1'b0);
        check_results("s3b", base, 1'b0, 16'h4000);

        // 4: backpressure on neuron 3 for 5 cycles
        rom_varied();
        base = n_res;
        dbase = n_done;
        do_start(vec_inc(), sc);
        k = 0;
        while (n_res < base + 3 && k < 500) begin
            tick();
            k++;
        end
        chk("s4_first_three", n_res - base, 32'd3);
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("s4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("s4_hold_idx", 32'(bus.out_idx), 32'd3);
            chk("s4_hold_data", 32'(bus.out_data), 32'd7);
            chk("s4_hold_rom_en", 32'(bus.rom_en), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("s4_next_valid", 32'(bus.out_valid), 32'd0);
        chk("s4_next_rom_en", 32'(bus.rom_en), 32'd1);
        chk("s4_next_addr", 32'(bus.rom_addr), 32'd64);
        wait_done("s4", sc, dbase, 294, 1'b0);
        check_results("s4", base, 1'b1, 16'd0);

        // 5: second start mid-pass with a different vector is ignored
        rom_uniform(16'd1, 16'd1);
        base = n_res;
        dbase = n_done;
        do_start(vec_all(16'd2), sc);
        for (int i = 0; i < 49; i++) tick();
        bus.start = 1'b1;
        bus.a_vec = vec_all(16'd7);
        tick();
        bus.start = 1'b0;
        chk("s5_still_busy", 32'(bus.busy), 32'd1);
        wait_done("s5", sc, dbase, 289, 1'b0);
        check_results("s5", base, 1'b0, 16'd31);

        // 6: reset mid-FETCH, then a clean pass
        dbase = n_done;
        do_start(vec_all(16'd2), sc);
        for (int i = 0; i < 99; i++) tick();
        chk("s6_pre_rom_en", 32'(bus.rom_en), 32'd1);
        chk("s6_pre_addr", 32'(bus.rom_addr), 32'd89);
        reset = 1'b0;
        #1;
        chk_all_zero("s6_reset");
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("s6_no_done", n_done - dbase, 32'd0);
        chk("s6_idle_busy", 32'(bus.busy), 32'd0);
        base = n_res;
        dbase = n_done;
        do_start(vec_all(16'd2), sc);
        wait_done("s6", sc, dbase, 289, 1'b0);
        check_results("s6", base, 1'b0, 16'd31);

        chk("rom_idle_during_emit", n_rom_emit, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
